// File: rtl/mem_bus_seq.sv
// ---------------------------------------------------------------------------
// mem_bus_seq
//
// Sequences one memory bus access (32-bit single beat or 64-bit double beat)
// for the bus interface unit. It takes a request from the control unit, loads
// the MAR from the chosen source, and runs one or two bus beats. Each beat
// waits up to TIMEOUT cycles for mem_ack. The access ends with a done pulse,
// or with done and err together if a beat times out.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   req         access request (sampled only while idle)
//   we          1 = write, 0 = read
//   dword       1 = 64-bit access (two beats), 0 = 32-bit access
//   addr_src    MAR source: 00 REG_OUT, 01 PC, 10 SP, 11 FP
//   mem_ack     memory finished the current beat
//   MAR_En*     MAR load strobes (REG_OUT / PC / SP / FP)
//   inc_en      MAR increment strobe between the two dword beats
//   Rd1_En      capture high word of read data
//   Rd0_En      capture low word of read data
//   WR1OE       drive high write word onto the bus
//   WR0OE       drive low write word onto the bus
//   mem_rd      memory read command
//   mem_wr      memory write command
//   busy        sequencer is not idle
//   done        one-cycle completion pulse
//   err         one-cycle timeout pulse (always together with done)
// ---------------------------------------------------------------------------
module mem_bus_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       we,
    input  logic       dword,
    input  logic [1:0] addr_src,
    input  logic       mem_ack,
    output logic       MAR_En,
    output logic       MAR_En_PC,
    output logic       MAR_En_SP,
    output logic       MAR_En_FP,
    output logic       inc_en,
    output logic       Rd1_En,
    output logic       Rd0_En,
    output logic       WR1OE,
    output logic       WR0OE,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACC0,
        INC,
        ACC1,
        FIN,
        ERR
    } state_t;

    // The wait counter gives up when it reaches this value without an ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       we_q, we_d;
    logic       dword_q, dword_d;
    logic [1:0] src_q, src_d;
    logic [7:0] cnt_q, cnt_d;
    logic       beatHigh;

    // State register, latched command and per-beat wait counter.
    // Reset returns to IDLE and clears the command, so every output drops
    // to zero at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            dword_q <= 1'b0;
            src_q   <= 2'b00;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            dword_q <= dword_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode. Strobes depend only on the state, with
    // one exception: the read capture strobes also require mem_ack. That
    // way the read buffer captures on the same edge that ends the beat.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        dword_d   = dword_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        beatHigh  = 1'b0;
        MAR_En    = 1'b0;
        MAR_En_PC = 1'b0;
        MAR_En_SP = 1'b0;
        MAR_En_FP = 1'b0;
        inc_en    = 1'b0;
        Rd1_En    = 1'b0;
        Rd0_En    = 1'b0;
        WR1OE     = 1'b0;
        WR0OE     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    dword_d = dword;
                    src_d   = addr_src;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                unique case (src_q)
                    2'b00: MAR_En    = 1'b1;
                    2'b01: MAR_En_PC = 1'b1;
                    2'b10: MAR_En_SP = 1'b1;
                    2'b11: MAR_En_FP = 1'b1;
                    default: ;
                endcase
                cnt_d   = 8'd0;
                state_d = ACC0;
            end

            // Big-endian beat mapping: the first beat of a dword uses the
            // high word. The second beat, and any single-word access, uses
            // the low word.
            ACC0, ACC1: begin
                beatHigh = (state_q == ACC0) && dword_q;
                if (we_q) begin
                    mem_wr = 1'b1;
                    WR1OE  = beatHigh;
                    WR0OE  = !beatHigh;
                end else begin
                    mem_rd = 1'b1;
                end
                // An ack in the last allowed cycle still counts as success.
                if (mem_ack) begin
                    if (!we_q) begin
                        Rd1_En = beatHigh;
                        Rd0_En = !beatHigh;
                    end
                    state_d = (state_q == ACC0 && dword_q) ? INC : FIN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            INC: begin
                inc_en  = 1'b1;
                cnt_d   = 8'd0;
                state_d = ACC1;
            end

            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_seq
//
// Self-checking bench for mem_bus_seq. Each directed task drives one
// scenario cycle by cycle and checks its strobes inline. Whenever it starts
// an access, it pushes the expected completion (cycle and err flag) onto a
// scoreboard. A negedge monitor pops that scoreboard on every done pulse. It
// also watches the mutual-exclusion rules on every cycle.
// ---------------------------------------------------------------------------
module tb_mem_bus_seq;

    localparam int TIMEOUT = 15;

    typedef struct {
        logic err;
        int   dueCyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req;
    logic       we;
    logic       dword;
    logic [1:0] addr_src;
    logic       mem_ack;
    logic       MAR_En, MAR_En_PC, MAR_En_SP, MAR_En_FP, inc_en;
    logic       Rd1_En, Rd0_En, WR1OE, WR0OE, mem_rd, mem_wr;
    logic       busy, done, err;

    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;
    logic monEn = 1'b0;
    exp_t sb[$];
    exp_t monE;

    wire [4:0]  marV  = {MAR_En, MAR_En_PC, MAR_En_SP, MAR_En_FP, inc_en};
    wire [5:0]  dataV = {mem_rd, mem_wr, WR1OE, WR0OE, Rd1_En, Rd0_En};
    wire [13:0] allO  = {marV, dataV, busy, done, err};

    mem_bus_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .dword     (dword),
        .addr_src  (addr_src),
        .mem_ack   (mem_ack),
        .MAR_En    (MAR_En),
        .MAR_En_PC (MAR_En_PC),
        .MAR_En_SP (MAR_En_SP),
        .MAR_En_FP (MAR_En_FP),
        .inc_en    (inc_en),
        .Rd1_En    (Rd1_En),
        .Rd0_En    (Rd0_En),
        .WR1OE     (WR1OE),
        .WR0OE     (WR0OE),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running clock and a cycle index used to time-stamp completions.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: checks exclusion rules every cycle and matches each done
    // pulse against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && monEn) begin
            nChecks++;
            if ($countones(marV) > 1 || (WR1OE && WR0OE) || (mem_rd && mem_wr))
                $display("[TB] FAIL exclusion @%0d: mar/inc=%b data=%b required at most one active",
                         cyc, marV, dataV);
            else
                nPass++;
            if (done || err) begin
                nChecks++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL unexpected_done @%0d: done=%b err=%b required no completion",
                             cyc, done, err);
                end else begin
                    monE = sb.pop_front();
                    if ({done, err} !== {1'b1, monE.err} || cyc != monE.dueCyc)
                        $display("[TB] FAIL completion: got done=%b err=%b cycle %0d, required done=1 err=%b cycle %0d",
                                 done, err, cyc, monE.err, monE.dueCyc);
                    else
                        nPass++;
                end
            end
        end
    end

    function automatic int pickWait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      return 0;
        else if (r < 7) return $urandom_range(1, 4);
        else if (r < 8) return TIMEOUT - 1;
        else if (r < 9) return TIMEOUT;
        else            return $urandom_range(5, TIMEOUT - 2);
    endfunction

    task automatic test_reset();
        int base;
        reset_n = 1'b0; req = 1'b1; we = 1'b1; dword = 1'b1; addr_src = 2'b11; mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (allO !== 14'd0) $display("[TB] FAIL reset_outputs: got %b required all zero", allO);
        else nPass++;
        req = 1'b0; we = 1'b0; dword = 1'b0; addr_src = 2'b00; mem_ack = 1'b0;
        // Release reset with a request pending; the next edge must accept it.
        @(negedge clk);
        monEn = 1'b1; reset_n = 1'b1; req = 1'b1; base = cyc;
        sb.push_back('{err: 1'b0, dueCyc: base + 3});
        @(posedge clk); #1; req = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({busy, marV} !== 6'b110000) $display("[TB] FAIL reset_first_req: got busy/mar=%b required 110000", {busy, marV});
        else nPass++;
        @(posedge clk); #1;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({done, err} !== 2'b10) $display("[TB] FAIL reset_first_done: got %b required 10", {done, err});
        else nPass++;
        @(posedge clk); #1;
        @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_back_idle: got busy=%b required 0", busy);
        else nPass++;
    endtask

    task automatic test_single_read();
        int base;
        @(posedge clk); #1;
        base = cyc; req = 1'b1; we = 1'b0; dword = 1'b0; addr_src = 2'b01; mem_ack = 1'b0;
        sb.push_back('{err: 1'b0, dueCyc: base + 3});
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        nChecks++;
        if (marV !== 5'b01000) $display("[TB] FAIL single_mar: got %b required 01000", marV);
        else nPass++;
        @(posedge clk); #1; mem_ack = 1'b1;
        @(negedge clk);
        nChecks++;
        if (dataV !== 6'b100001) $display("[TB] FAIL single_rd: got %b required 100001", dataV);
        else nPass++;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({done, err, dataV} !== 8'b10_000000) $display("[TB] FAIL single_done: got %b required 10000000", {done, err, dataV});
        else nPass++;
        @(posedge clk); #1;
    endtask

    task automatic test_dword_write();
        int base;
        logic [4:0] expMar;
        logic [5:0] expData;
        @(posedge clk); #1;
        base = cyc; req = 1'b1; we = 1'b1; dword = 1'b1; addr_src = 2'b10; mem_ack = 1'b0;
        sb.push_back('{err: 1'b0, dueCyc: base + 9});
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            req = 1'b0;
            mem_ack = (k == 4 || k == 8);
            expMar  = (k == 1) ? 5'b00100 : (k == 5) ? 5'b00001 : 5'b00000;
            expData = (k >= 2 && k <= 4) ? 6'b011000 : (k >= 6 && k <= 8) ? 6'b010100 : 6'b000000;
            @(negedge clk);
            nChecks++;
            if ({marV, dataV, done} !== {expMar, expData, k == 9})
                $display("[TB] FAIL dword_write c%0d: got mar=%b data=%b done=%b required mar=%b data=%b done=%b",
                         k, marV, dataV, done, expMar, expData, k == 9);
            else
                nPass++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_timeout(input logic ackLast);
        int base;
        logic [5:0] expData;
        @(posedge clk); #1;
        base = cyc; req = 1'b1; we = 1'b0; dword = 1'b1; addr_src = 2'b01; mem_ack = 1'b0;
        // ackLast: ack arrives in the final allowed cycle (a plain single beat here).
        if (ackLast) dword = 1'b0;
        sb.push_back('{err: !ackLast, dueCyc: base + 17});
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            req = 1'b0;
            mem_ack = ackLast && (k == 16);
            expData = 6'b000000;
            if (k >= 2 && k <= 16) expData = (ackLast && k == 16) ? 6'b100001 : 6'b100000;
            @(negedge clk);
            nChecks++;
            if ({dataV, done, err} !== {expData, k == 17, k == 17 && !ackLast})
                $display("[TB] FAIL timeout(ackLast=%0d) c%0d: got data=%b done=%b err=%b required data=%b done=%b err=%b",
                         ackLast, k, dataV, done, err, expData, k == 17, k == 17 && !ackLast);
            else
                nPass++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_ignored_req();
        int base;
        @(posedge clk); #1;
        base = cyc; req = 1'b1; we = 1'b0; dword = 1'b0; addr_src = 2'b01; mem_ack = 1'b1;
        sb.push_back('{err: 1'b0, dueCyc: base + 3});
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            req = (k == 2);
            addr_src = 2'b11;
            @(negedge clk);
            nChecks++;
            if ({busy, marV} !== {k <= 3, (k == 1) ? 5'b01000 : 5'b00000})
                $display("[TB] FAIL ignored_req c%0d: got busy/mar=%b required busy=%0d mar=%b",
                         k, {busy, marV}, k <= 3, (k == 1) ? 5'b01000 : 5'b00000);
            else
                nPass++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base;
        logic expBusy;
        @(posedge clk); #1;
        base = cyc; req = 1'b1; we = 1'b0; dword = 1'b0; addr_src = 2'b00; mem_ack = 1'b1;
        sb.push_back('{err: 1'b0, dueCyc: base + 3});
        sb.push_back('{err: 1'b0, dueCyc: base + 7});
        sb.push_back('{err: 1'b0, dueCyc: base + 11});
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            req = (k <= 8);
            expBusy = (k % 4) != 0;
            @(negedge clk);
            nChecks++;
            if ({busy, MAR_En} !== {expBusy, (k % 4) == 1})
                $display("[TB] FAIL back_to_back c%0d: got busy=%b MAR_En=%b required busy=%b MAR_En=%b",
                         k, busy, MAR_En, expBusy, (k % 4) == 1);
            else
                nPass++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_midop();
        int base;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; dword = 1'b1; addr_src = 2'b00; mem_ack = 1'b0;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1; mem_ack = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        nChecks++;
        if (dataV !== 6'b100000) $display("[TB] FAIL midop_in_acc1: got %b required 100000", dataV);
        else nPass++;
        #1 reset_n = 1'b0;
        #1;
        nChecks++;
        if (allO !== 14'd0) $display("[TB] FAIL midop_reset_async: got %b required all zero", allO);
        else nPass++;
        @(posedge clk); @(posedge clk); #1;
        nChecks++;
        if (allO !== 14'd0) $display("[TB] FAIL midop_reset_hold: got %b required all zero", allO);
        else nPass++;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        base = cyc; req = 1'b1; we = 1'b1; dword = 1'b0; addr_src = 2'b11;
        sb.push_back('{err: 1'b0, dueCyc: base + 3});
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        nChecks++;
        if (marV !== 5'b00010) $display("[TB] FAIL midop_after_mar: got %b required 00010", marV);
        else nPass++;
        @(posedge clk); #1; mem_ack = 1'b1;
        @(negedge clk);
        nChecks++;
        if (dataV !== 6'b010100) $display("[TB] FAIL midop_after_wr: got %b required 010100", dataV);
        else nPass++;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            logic       rWe, rDw, ok0, expErrTx, inAcc, high, ackNow;
            logic [1:0] rSrc;
            logic [4:0] expMar;
            logic [5:0] expData;
            int         gap, w0, w1, len0, len1, s1, incK, doneK, base;
            rWe  = 1'($urandom_range(0, 1));
            rDw  = 1'($urandom_range(0, 1));
            rSrc = 2'($urandom_range(0, 3));
            gap  = $urandom_range(0, 2);
            w0   = pickWait();
            w1   = pickWait();
            ok0  = (w0 < TIMEOUT);
            len0 = ok0 ? w0 + 1 : TIMEOUT;
            len1 = (w1 < TIMEOUT) ? w1 + 1 : TIMEOUT;
            s1   = 2 + len0 + 1;
            incK = (rDw && ok0) ? 2 + len0 : -1;
            doneK    = (rDw && ok0) ? s1 + len1 : 2 + len0;
            expErrTx = (rDw && ok0) ? (w1 >= TIMEOUT) : !ok0;
            repeat (gap) begin
                @(posedge clk); #1;
                req = 1'b0; mem_ack = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1)); dword = 1'($urandom_range(0, 1));
                addr_src = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            base = cyc; req = 1'b1; we = rWe; dword = rDw; addr_src = rSrc;
            mem_ack = 1'($urandom_range(0, 1));
            sb.push_back('{err: expErrTx, dueCyc: base + doneK});
            for (int k = 1; k <= doneK; k++) begin
                @(posedge clk); #1;
                inAcc = 1'b0; high = 1'b0; ackNow = 1'b0;
                if (k >= 2 && k < 2 + len0) begin
                    inAcc = 1'b1; high = rDw; ackNow = (k - 2 == w0);
                end else if (rDw && ok0 && k >= s1 && k < s1 + len1) begin
                    inAcc = 1'b1; high = 1'b0; ackNow = (k - s1 == w1);
                end
                mem_ack  = inAcc ? ackNow : 1'($urandom_range(0, 1));
                req      = 1'($urandom_range(0, 1));
                we       = 1'($urandom_range(0, 1));
                dword    = 1'($urandom_range(0, 1));
                addr_src = 2'($urandom_range(0, 3));
                expMar   = (k == 1) ? (5'b10000 >> rSrc) : (k == incK) ? 5'b00001 : 5'b00000;
                expData  = 6'b000000;
                if (inAcc)
                    expData = {!rWe, rWe, rWe & high, rWe & !high,
                               !rWe & ackNow & high, !rWe & ackNow & !high};
                @(negedge clk);
                nChecks++;
                if ({marV, dataV, done, err} !== {expMar, expData, k == doneK, k == doneK && expErrTx})
                    $display("[TB] FAIL random t%0d c%0d: got mar=%b data=%b done=%b err=%b required mar=%b data=%b done=%b err=%b",
                             t, k, marV, dataV, done, err, expMar, expData, k == doneK, k == doneK && expErrTx);
                else
                    nPass++;
            end
        end
        @(posedge clk); #1;
        req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_drain();
        @(negedge clk);
        nChecks++;
        if (sb.size() != 0 || busy !== 1'b0)
            $display("[TB] FAIL drain: got %0d pending completions busy=%b required 0 pending busy=0", sb.size(), busy);
        else
            nPass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_dword_write();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_ignored_req();
        test_back_to_back();
        test_reset_midop();
        test_random();
        test_drain();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
